fpu_div16: RTL

- Iterative IEEE-754 half-precision divider computing result = a / b: the inverse operation of the FP16 multiplier in the same FPU.
- Uses a restoring radix-2 divider that produces one quotient bit per clock, so it is multi-cycle where the FP16 add/mul units are combinational.
- Uses valid/ready handshakes on both input and output. It sits beside the FP16 add/mul units, and the FPU control logic issues divide operations to it.

---
 rtl/fpu_div16.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_div16.sv
// Iterative FP16 divider (result = a / b): restoring radix-2, one quotient bit per clock.
// Define FPU_DIV_ROUND_EN for round-to-nearest-even; the default build truncates.
module fpu_div16 #(
   parameter int ITERS = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result
);

   typedef enum logic [1:0] {IDLE, DIV, PACK, DONE} state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [4:0]  ea_q, ea_d;
   logic [4:0]  eb_q, eb_d;
   logic [10:0] mb_q, mb_d;
   logic [11:0] rem_q, rem_d;
   logic [12:0] quo_q, quo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] result_q, result_d;

   // Operand classification (denormals flush to zero, exp==31 is Inf regardless of mantissa)
   logic        a_zero, b_zero, a_inf, b_inf, in_sign;
   logic        is_special;
   logic [15:0] special_res;

   always_comb begin
      a_zero      = (a[14:10] == 5'd0);
      b_zero      = (b[14:10] == 5'd0);
      a_inf       = (a[14:10] == 5'h1F);
      b_inf       = (b[14:10] == 5'h1F);
      in_sign     = a[15] ^ b[15];
      is_special  = 1'b1;
      special_res = 16'h0000;
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         special_res = 16'h7E00;
      end else if (b_zero || a_inf) begin
         special_res = {in_sign, 5'h1F, 10'h000};
      end else if (a_zero || b_inf) begin
         special_res = {in_sign, 15'h0000};
      end else begin
         is_special = 1'b0;
      end
   end

   // One restoring iteration
   logic        rem_ge;
   logic [11:0] rem_sub;
   logic [11:0] rem_shift;

   always_comb begin
      rem_ge    = (rem_q >= {1'b0, mb_q});
      rem_sub   = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
      rem_shift = {rem_sub[10:0], 1'b0};
   end

   // Normalise, optionally round, and range-check the finished quotient
   logic [9:0]        pk_mant;
   logic              pk_guard, pk_sticky;
   logic signed [6:0] pk_exp;
   logic [15:0]       pack_res;

   always_comb begin
      if (quo_q[12]) begin
         pk_mant   = quo_q[11:2];
         pk_guard  = quo_q[1];
         pk_sticky = quo_q[0] | (rem_q != 12'd0);
         pk_exp    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 7'sd15;
      end else begin
         pk_mant   = quo_q[10:1];
         pk_guard  = quo_q[0];
         pk_sticky = (rem_q != 12'd0);
         pk_exp    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 7'sd14;
      end
`ifdef FPU_DIV_ROUND_EN
      if (pk_guard && (pk_sticky || pk_mant[0])) begin
         if (pk_mant == 10'h3FF) begin
            pk_mant = 10'h000;
            pk_exp  = pk_exp + 7'sd1;
         end else begin
            pk_mant = pk_mant + 10'd1;
         end
      end
`endif
      if (pk_exp >= 7'sd31) begin
         pack_res = {sign_q, 5'h1F, 10'h000};
      end else if (pk_exp <= 7'sd0) begin
         pack_res = {sign_q, 15'h0000};
      end else begin
         pack_res = {sign_q, pk_exp[4:0], pk_mant};
      end
   end

`ifndef FPU_DIV_ROUND_EN
   // Guard and sticky only feed the rounding increment
   logic unused_round;
   assign unused_round = pk_guard ^ pk_sticky;
`endif

   // NOTE: every next-state signal gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      ea_d     = ea_q;
      eb_d     = eb_q;
      mb_d     = mb_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d = in_sign;
               ea_d   = a[14:10];
               eb_d   = b[14:10];
               mb_d   = {1'b1, b[9:0]};
               if (is_special) begin
                  result_d = special_res;
                  state_d  = DONE;
               end else begin
                  rem_d   = {2'b01, a[9:0]};
                  quo_d   = 13'd0;
                  cnt_d   = 4'd0;
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            rem_d = rem_shift;
            quo_d = {quo_q[11:0], rem_ge};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(ITERS - 1)) begin
               state_d = PACK;
            end
         end
         PACK: begin
            result_d = pack_res;
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments and resets asynchronously, so a mid-divide reset aborts at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         ea_q     <= 5'd0;
         eb_q     <= 5'd0;
         mb_q     <= 11'd0;
         rem_q    <= 12'd0;
         quo_q    <= 13'd0;
         cnt_q    <= 4'd0;
         result_q <= 16'h0000;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         mb_q     <= mb_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;

endmodule
